// File: rtl/imem_responder.sv
// Instruction fetch responder: builds a 64-bit window from 1, 2 or 4 halfword
// reads of a variable-latency 16-bit backing memory. Every output comes
// straight from a flop, so the fetch unit may derive its next address from
// o_imem_data_valid without creating a combinational loop.
module imem_responder #(
    parameter int MEM_AW     = 16,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       i_imem_addr,
    input  logic              i_imem_addr_valid,
    output logic [63:0]       o_imem_data,
    output logic              o_imem_data_valid,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic              o_mem_rd_en,
    input  logic [15:0]       i_mem_rdata,
    input  logic              i_mem_rvalid,
    output logic              o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t            r_state;
    logic [MEM_AW-1:0] r_ha;
    logic [1:0]        r_beat;
    logic [1:0]        r_last;
    logic [63:0]       r_buf;
    logic              r_valid;
    logic              r_rd_en;
    logic [MEM_AW-1:0] r_mem_addr;
    logic              r_busy;

    logic [MEM_AW-1:0] w_req_ha;
    logic              w_new_addr;
    logic [1:0]        w_first_last;
    logic [1:0]        w_last;
    logic              w_is_last;
    logic [1:0]        w_next_beat;
    logic [MEM_AW-1:0] w_next_addr;
    logic [MEM_AW-1:0] w_drain_ha;
    logic [5:0]        w_slot_lsb;
    logic              w_unused_addr_bits;

    // Byte address bit 0 and the bits above the memory range never matter.
    assign w_unused_addr_bits = ^{i_imem_addr[63:MEM_AW+1], i_imem_addr[0]};

    assign w_req_ha    = i_imem_addr[MEM_AW:1];
    assign w_new_addr  = i_imem_addr_valid && (w_req_ha != r_ha);

    // Last beat index (N-1) decoded from the first halfword's length bits.
    assign w_first_last = !EARLY_TERM     ? 2'd3 :
                          !i_mem_rdata[15] ? 2'd0 :
                          i_mem_rdata[14]  ? 2'd3 : 2'd1;
    assign w_last       = (r_beat == 2'd0) ? w_first_last : r_last;
    assign w_is_last    = (r_beat == w_last);
    assign w_next_beat  = r_beat + 2'd1;
    assign w_next_addr  = r_ha + MEM_AW'(w_next_beat);
    assign w_drain_ha   = w_new_addr ? w_req_ha : r_ha;

    // Slot 0 lives in the top halfword, slot 3 in the bottom one.
    assign w_slot_lsb   = {~r_beat, 4'b0000};

    // Fetch sequencer: one read outstanding at most, registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ha       <= '0;
            r_beat     <= '0;
            r_last     <= '0;
            r_buf      <= '0;
            r_valid    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_imem_addr_valid) begin
                        r_ha       <= w_req_ha;
                        r_mem_addr <= w_req_ha;
                        r_beat     <= '0;
                        r_buf      <= '0;
                        r_rd_en    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_new_addr) begin
                        r_ha    <= w_req_ha;
                        r_state <= S_DRAIN;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_new_addr) begin
                        r_ha <= w_req_ha;
                        if (i_mem_rvalid) begin
                            r_mem_addr <= w_req_ha;
                            r_beat     <= '0;
                            r_buf      <= '0;
                            r_rd_en    <= 1'b1;
                            r_state    <= S_ISSUE;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (i_mem_rvalid) begin
                        r_buf[w_slot_lsb +: 16] <= i_mem_rdata;
                        if (r_beat == 2'd0) begin
                            r_last <= w_first_last;
                        end
                        if (w_is_last) begin
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_beat     <= w_next_beat;
                            r_mem_addr <= w_next_addr;
                            r_rd_en    <= 1'b1;
                            r_state    <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    if (!i_imem_addr_valid) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_req_ha != r_ha) begin
                        r_ha       <= w_req_ha;
                        r_mem_addr <= w_req_ha;
                        r_beat     <= '0;
                        r_buf      <= '0;
                        r_valid    <= 1'b0;
                        r_rd_en    <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_DRAIN: begin
                    r_ha <= w_drain_ha;
                    if (i_mem_rvalid) begin
                        r_mem_addr <= w_drain_ha;
                        r_beat     <= '0;
                        r_buf      <= '0;
                        r_rd_en    <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_imem_data       = r_buf;
    assign o_imem_data_valid = r_valid;
    assign o_mem_addr        = r_mem_addr;
    assign o_mem_rd_en       = r_rd_en;
    assign o_busy            = r_busy;

endmodule
